// File: rtl/mor1kx_rf_multiport.sv
// Multi-port GPR file with per-port read hold registers, result forwarding and optional
// context banks. Defining MOR1KX_RF_CLEAR_EN adds a post-reset sequencer that zeroes the RAM.
module mor1kx_rf_multiport #(
    parameter int NUM_RD_PORTS = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_CONTEXTS = 1,
    parameter int BYP_STAGES   = 2,
    localparam int CTX_WIDTH   = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req_i,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_adr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_dat_o,
    input  logic [BYP_STAGES-1:0]              byp_vld_i,
    input  logic [BYP_STAGES*ADDR_WIDTH-1:0]   byp_adr_i,
    input  logic [BYP_STAGES*DATA_WIDTH-1:0]   byp_dat_i,
    input  logic                               wr_en_i,
    input  logic [ADDR_WIDTH-1:0]              wr_adr_i,
    input  logic [DATA_WIDTH-1:0]              wr_dat_i,
    input  logic [CTX_WIDTH-1:0]               ctx_i,
    output logic                               busy_o
);

    localparam int CTX_BITS = $clog2(NUM_CONTEXTS);
    localparam int PHYS_W   = ADDR_WIDTH + CTX_BITS;
    localparam int DEPTH    = NUM_CONTEXTS << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] lat_adr [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0] hold    [NUM_RD_PORTS];
    logic [CTX_WIDTH-1:0]  lat_ctx;
    logic                  busy;
    logic                  rd_req_eff;
    logic                  wr_en_eff;
    logic                  wr_hit;

    // With a single context the shift pushes ctx out entirely, leaving the plain address.
    function automatic logic [PHYS_W-1:0] phys(input logic [CTX_WIDTH-1:0] c,
                                               input logic [ADDR_WIDTH-1:0] a);
        return (PHYS_W'(c) << ADDR_WIDTH) | PHYS_W'(a);
    endfunction

    assign rd_req_eff = rd_req_i & ~busy;
    assign wr_en_eff  = wr_en_i & ~busy;
    assign wr_hit     = wr_en_eff && (wr_adr_i != '0);
    assign busy_o     = busy;

`ifdef MOR1KX_RF_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} clr_state_t;
    localparam logic [PHYS_W-1:0] LAST_IDX = PHYS_W'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        state_next;
    logic [PHYS_W-1:0] clr_cnt;

    // Reset (even mid-sequence) restarts clearing from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == LAST_IDX)
            state_next = IDLE;
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_cnt] <= '0;
        else if (wr_hit)
            mem[phys(ctx_i, wr_adr_i)] <= wr_dat_i;
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (wr_hit)
            mem[phys(ctx_i, wr_adr_i)] <= wr_dat_i;
    end
`endif

    // Hold registers capture RAM on a read request (with write-through) and then track
    // writes to the latched location, which includes the context latched with the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_ctx <= '0;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                lat_adr[p] <= '0;
                hold[p]    <= '0;
            end
        end else if (rd_req_eff) begin
            lat_ctx <= ctx_i;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                lat_adr[p] <= rd_adr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                if (wr_hit && wr_adr_i == rd_adr_i[p*ADDR_WIDTH +: ADDR_WIDTH])
                    hold[p] <= wr_dat_i;
                else
                    hold[p] <= mem[phys(ctx_i, rd_adr_i[p*ADDR_WIDTH +: ADDR_WIDTH])];
            end
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++)
                if (wr_hit && phys(ctx_i, wr_adr_i) == phys(lat_ctx, lat_adr[p]))
                    hold[p] <= wr_dat_i;
        end
    end

    for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_port
        logic [DATA_WIDTH-1:0] port_dat;

        // Walk stages oldest-first so the youngest matching stage wins.
        always_comb begin
            port_dat = hold[gp];
            if (wr_en_eff && wr_adr_i == lat_adr[gp])
                port_dat = wr_dat_i;
            for (int s = BYP_STAGES - 1; s >= 0; s--)
                if (byp_vld_i[s] && byp_adr_i[s*ADDR_WIDTH +: ADDR_WIDTH] == lat_adr[gp])
                    port_dat = byp_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
            if (lat_adr[gp] == '0 || busy)
                port_dat = '0;
        end

        assign rd_dat_o[gp*DATA_WIDTH +: DATA_WIDTH] = port_dat;
    end

endmodule

// File: tb/tb_mor1kx_rf_multiport.sv
// Directed bench for mor1kx_rf_multiport (3 ports, 2 contexts, 2 bypass stages).
// Clear-sequence checks are compiled in when MOR1KX_RF_CLEAR_EN is defined.
module tb_mor1kx_rf_multiport;

    localparam int NRP   = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NC    = 2;
    localparam int BYP   = 2;
    localparam int DEPTH = NC << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req_i;
    logic [NRP*AW-1:0] rd_adr_i;
    logic [NRP*DW-1:0] rd_dat_o;
    logic [BYP-1:0]    byp_vld_i;
    logic [BYP*AW-1:0] byp_adr_i;
    logic [BYP*DW-1:0] byp_dat_i;
    logic              wr_en_i;
    logic [AW-1:0]     wr_adr_i;
    logic [DW-1:0]     wr_dat_i;
    logic [0:0]        ctx_i;
    logic              busy_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mor1kx_rf_multiport #(
        .NUM_RD_PORTS(NRP),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_CONTEXTS(NC),
        .BYP_STAGES  (BYP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req_i (rd_req_i),
        .rd_adr_i (rd_adr_i),
        .rd_dat_o (rd_dat_o),
        .byp_vld_i(byp_vld_i),
        .byp_adr_i(byp_adr_i),
        .byp_dat_i(byp_dat_i),
        .wr_en_i  (wr_en_i),
        .wr_adr_i (wr_adr_i),
        .wr_dat_i (wr_dat_i),
        .ctx_i    (ctx_i),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] port(input int p);
        return rd_dat_o[p*DW +: DW];
    endfunction

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [0:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ctx_i    = c;
        wr_en_i  = 1'b1;
        wr_adr_i = a;
        wr_dat_i = d;
        tick();
        wr_en_i  = 1'b0;
    endtask

    task automatic read_req(input logic [0:0] c, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ctx_i    = c;
        rd_req_i = 1'b1;
        rd_adr_i = {a2, a1, a0};
        tick();
        rd_req_i = 1'b0;
    endtask

`ifdef MOR1KX_RF_CLEAR_EN
    task automatic measure_busy(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 4 * DEPTH) begin
            tick();
            n++;
        end
        check_output(tag, DW'(n), DW'(DEPTH));
    endtask
`endif

    initial begin
        rst = 1'b1; rd_req_i = 1'b0; rd_adr_i = '0;
        byp_vld_i = '0; byp_adr_i = '0; byp_dat_i = '0;
        wr_en_i = 1'b0; wr_adr_i = '0; wr_dat_i = '0; ctx_i = '0;
        tick();
        tick();
        rst = 1'b0;
        check_output("reset_p0", port(0), 32'h0);
        check_output("reset_p1", port(1), 32'h0);
        check_output("reset_p2", port(2), 32'h0);

`ifdef MOR1KX_RF_CLEAR_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("busy_after_rst", DW'(busy_o), 32'h1);
        measure_busy("busy_len");
        for (int c = 0; c < NC; c++)
            for (int a = 1; a < 32; a += 3) begin
                read_req(1'(c), AW'(a), AW'((a + 1) % 32), AW'((a + 2) % 32));
                check_output("cleared_p0", port(0), 32'h0);
                check_output("cleared_p1", port(1), 32'h0);
                check_output("cleared_p2", port(2), 32'h0);
            end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        measure_busy("busy_len_restart");
`else
        check_output("busy_tied_low", DW'(busy_o), 32'h0);
`endif

        // Write then read with one-cycle latency
        write_reg(1'b0, 5'd3, 32'h11);
        read_req(1'b0, 5'd3, 5'd0, 5'd0);
        check_output("r3_read", port(0), 32'h11);
        check_output("addr0_port1", port(1), 32'h0);

        // Held port tracks a later write to its address
        write_reg(1'b0, 5'd5, 32'h05);
        read_req(1'b0, 5'd3, 5'd5, 5'd0);
        check_output("r5_initial", port(1), 32'h05);
        wr_en_i = 1'b1; wr_adr_i = 5'd5; wr_dat_i = 32'hAB;
        #1;
        check_output("r5_fwd_same_cycle", port(1), 32'hAB);
        check_output("r3_unaffected", port(0), 32'h11);
        tick();
        wr_en_i = 1'b0;
        #1;
        check_output("r5_held_after_wr", port(1), 32'hAB);

        // Forwarding priority: stage0 > stage1 > writeback > hold
        write_reg(1'b0, 5'd7, 32'h07);
        read_req(1'b0, 5'd7, 5'd5, 5'd7);
        byp_vld_i = 2'b11;
        byp_adr_i = {5'd7, 5'd7};
        byp_dat_i = {32'h2, 32'h1};
        wr_en_i = 1'b1; wr_adr_i = 5'd7; wr_dat_i = 32'h3;
        #1;
        check_output("byp_stage0", port(0), 32'h1);
        check_output("byp_same_addr_p2", port(2), 32'h1);
        check_output("byp_other_port", port(1), 32'hAB);
        byp_adr_i = {5'd7, 5'd8};
        #1;
        check_output("byp_stage0_miss", port(0), 32'h2);
        byp_adr_i = {5'd7, 5'd7};
        byp_vld_i = 2'b10;
        #1;
        check_output("byp_stage1", port(0), 32'h2);
        byp_vld_i = 2'b00;
        #1;
        check_output("byp_wr_fwd", port(0), 32'h3);
        tick();
        wr_en_i = 1'b0;
        #1;
        check_output("r7_held", port(0), 32'h3);

        // Write-through when read request and write coincide
        ctx_i = 1'b0;
        wr_en_i = 1'b1; wr_adr_i = 5'd9; wr_dat_i = 32'h99;
        read_req(1'b0, 5'd9, 5'd0, 5'd0);
        wr_en_i = 1'b0;
        #1;
        check_output("write_through", port(0), 32'h99);

        // Contexts are separate banks
        write_reg(1'b0, 5'd4, 32'h55);
        write_reg(1'b1, 5'd4, 32'h66);
        read_req(1'b0, 5'd4, 5'd0, 5'd0);
        check_output("ctx0_r4", port(0), 32'h55);
        read_req(1'b1, 5'd4, 5'd0, 5'd0);
        check_output("ctx1_r4", port(0), 32'h66);
        write_reg(1'b0, 5'd4, 32'h77);
        #1;
        check_output("ctx_held_unchanged", port(0), 32'h66);
        read_req(1'b0, 5'd4, 5'd4, 5'd0);
        check_output("ctx0_r4_new", port(1), 32'h77);

        // Address 0 always reads zero
        write_reg(1'b0, 5'd0, 32'hFF);
        read_req(1'b0, 5'd0, 5'd4, 5'd0);
        check_output("r0_after_write", port(0), 32'h0);
        byp_vld_i = 2'b01; byp_adr_i = {5'd0, 5'd0}; byp_dat_i = {32'h0, 32'hFF};
        #1;
        check_output("r0_byp_ignored", port(0), 32'h0);
        byp_vld_i = 2'b00;

        // Reset clears held data
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_clears_hold", port(1), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
